// File: rtl/alu_issue_stage.sv
// alu_issue_stage: valid/ready wrapper around the combinational alu.
// A MAIN register (with a one-entry SKID behind it) presents operands to the
// alu. The alu's result is captured into an OUT register for writeback.
// in_ready depends only on registered SKID state, so it never follows
// out_ready combinationally.
module alu_issue_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [1:0]       occupancy
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_a;
    logic [WIDTH-1:0] r_main_b;
    logic [2:0]       r_main_ctrl;

    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_a;
    logic [WIDTH-1:0] r_skid_b;
    logic [2:0]       r_skid_ctrl;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_zero;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_adv;

    // Handshake qualifiers; adv moves MAIN into OUT when OUT is free or draining
    assign w_in_ready = reset && !r_skid_valid;
    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_adv      = r_main_valid && (!r_out_valid || out_ready);

    // Pipeline register update: MAIN/SKID/OUT move together on each edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_valid <= 1'b0;
            r_main_a     <= '0;
            r_main_b     <= '0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_ctrl  <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_zero   <= alu_zero;
            if (r_skid_valid) begin
                // in_ready is low here, so no input can collide with the refill
                r_main_a     <= r_skid_a;
                r_main_b     <= r_skid_b;
                r_main_ctrl  <= r_skid_ctrl;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main_a     <= in_a;
                r_main_b     <= in_b;
                r_main_ctrl  <= in_ctrl;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else begin
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_in_fire) begin
                if (!r_main_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_a     <= in_a;
                    r_main_b     <= in_b;
                    r_main_ctrl  <= in_ctrl;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_a     <= in_a;
                    r_skid_b     <= in_b;
                    r_skid_ctrl  <= in_ctrl;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign alu_a      = r_main_valid ? r_main_a    : '0;
    assign alu_b      = r_main_valid ? r_main_b    : '0;
    assign alu_ctrl   = r_main_valid ? r_main_ctrl : 3'b000;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign occupancy  = 2'({1'b0, r_main_valid}) + 2'({1'b0, r_skid_valid})
                      + 2'({1'b0, r_out_valid});

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-stage valid/ready execute wrapper placed directly upstream of the single-cycle `alu`.
- Accepts operand/control packets from decode through a 2-entry skid buffer.
- Drives the held packet into the combinational `alu`.
- Registers the returned `ALUResult`/`Z` into an output stage for writeback.
- Provides full-throughput streaming with backpressure, so the execute path can be pipelined without touching `alu` itself.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match the attached `alu` instance.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream packet valid.
- `in_ready`  out  1  stage can accept a packet this cycle.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_ctrl`  in  3  ALUControl code (000 add, 001 sub; others pass through unchanged).
- `alu_a`  out  WIDTH  to `alu.a_in`.
- `alu_b`  out  WIDTH  to `alu.b_in`.
- `alu_ctrl`  out  3  to `alu.ALUControl`.
- `alu_result`  in  WIDTH  from `alu.ALUResult`.
- `alu_zero`  in  1  from `alu.Z`.
- `out_valid`  out  1  result register holds a valid result.
- `out_ready`  in  1  downstream accepts the result this cycle.
- `out_result`  out  WIDTH  registered ALU result.
- `out_zero`  out  1  registered zero flag.
- `occupancy`  out  2  number of valid entries (main + skid + output), range 0..3.

## Operation
State consists of three valid-tagged registers: MAIN, SKID and OUT.

Transfers:
- Input transfer: `in_valid && in_ready`.
- Output transfer: `out_valid && out_ready`.
- Advance condition: `adv = main_valid && (!out_valid || out_ready)`.

Per clock edge, applied together:
- **adv, skid empty, input transfer:** MAIN→OUT; input→MAIN.
- **adv, skid valid:** MAIN→OUT; SKID→MAIN; SKID empties. No input can arrive, because `in_ready` is 0.
- **adv, no input:** MAIN→OUT; MAIN empties.
- **!adv, input transfer:**
  - Input→MAIN if MAIN is empty.
  - Otherwise input→SKID.
- **Output transfer without adv:** OUT empties.

Combinational behaviour:
- `in_ready = reset && !skid_valid`. SKID occupancy is registered, so `in_ready` never depends combinationally on `out_ready`.
- `alu_a/alu_b/alu_ctrl` = MAIN contents when `main_valid`, otherwise all zeros.

Capture and ordering:
- On adv, OUT captures `alu_result` and `alu_zero` as seen in the same cycle.
- Packets leave in strict arrival order. No packet is dropped or duplicated.

Arithmetic:
- Performed entirely by `alu`; this block does no arithmetic.
- Width-`WIDTH` results wrap modulo 2^WIDTH.
- Unsupported `in_ctrl` codes give `out_result=0`, `out_zero=1`.

## Timing
- Reset (`reset` low, asynchronous):
  - All valid bits clear.
  - MAIN/SKID/OUT data registers and `out_result` are 0; `out_zero` is 0.
  - `in_ready=0`, `occupancy=0`, `alu_*`=0.
- First cycle after release: `in_ready=1`.
- Latency: packet accepted in cycle k → driven on `alu_*` in cycle k+1 → `out_valid` with result in cycle k+2.
- Throughput: 1 packet/cycle sustained while `out_ready=1`.
- Backpressure with `out_ready=0` and a continuous input stream:
  - OUT fills, then MAIN, then SKID.
  - `in_ready` falls the cycle after SKID fills.
  - `occupancy=3`.
- Recovery: `out_ready` asserted in cycle j → `in_ready` high again in cycle j+1.
- Simultaneous input and output transfer with MAIN valid: occupancy unchanged.
- `out_result`/`out_zero` hold stable while `out_valid && !out_ready`.
- Reset asserted mid-stream: every in-flight packet is discarded immediately. After release the stage behaves as freshly reset; no stale `out_valid`.

## Test plan
1. **Basic add:** `in_a=5`, `in_b=7`, `in_ctrl=000`, `out_ready=1` → `out_valid` two cycles later with `out_result=12`, `out_zero=0`.
2. **Subtract to zero and wrap:**
   - `9-9` via ctrl 001 → `out_result=0`, `out_zero=1`.
   - `0xFFFFFFFF+1` via ctrl 000 → `out_result=0`, `out_zero=1`.
   - `0-1` via ctrl 001 → `0xFFFFFFFF`.
3. **Backpressure:**
   - Stimulus: `out_ready=0`; stream packets 1+1, 2+2, 3+3, 4+4.
   - Expected: first three accepted, `in_ready` low after the third, `occupancy=3`, result 2 held stable.
   - Then raise `out_ready` → results 2, 4, 6, 8 in order, none lost.
4. **Streaming:** 200 random add/sub packets with `in_valid=1`, `out_ready=1` → one result per cycle, all match the reference model, `occupancy` ≤ 2.
5. **Reset mid-operation:**
   - Stimulus: `occupancy=3`; pulse `reset` low asynchronously between edges.
   - Expected: outputs go to reset values immediately; after release, no spurious `out_valid`; next packet 3+4 → 7.
6. **Illegal ctrl:** `in_ctrl=111`, `in_a=10`, `in_b=20` → `out_result=0`, `out_zero=1`, packet ordering unaffected.
